// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// One outstanding transaction; memory-side signals are registered; LS has priority with starvation cap.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STRB_W     = DATA_W / 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic              IfGnt,
    output logic              IfRvalid,
    output logic [DATA_W-1:0] IfRdata,
    input  logic              Flush,
    input  logic              LsReq,
    input  logic              LsWe,
    input  logic [ADDR_W-1:0] LsAddr,
    input  logic [DATA_W-1:0] LsWdata,
    input  logic [STRB_W-1:0] LsWmask,
    output logic              LsGnt,
    output logic              LsRvalid,
    output logic [DATA_W-1:0] LsRdata,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    output logic [STRB_W-1:0] MemWmask,
    input  logic              MemGnt,
    input  logic              MemRvalid,
    input  logic [DATA_W-1:0] MemRdata,
    output logic              HoldIf,
    output logic              HoldLs
);
    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
    typedef enum logic {OwnIf, OwnLs} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              kill_q, kill_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              arb_idle;
    logic              if_wins;

    // Requests are ignored while reset is held, so grants and holds stay low.
    assign arb_idle = Rst && (state_q == StIdle);
    assign if_wins  = IfReq && (!LsReq || (starve_q == StarveLim));
    assign IfGnt    = arb_idle && if_wins;
    assign LsGnt    = arb_idle && LsReq && !if_wins;

    assign IfRvalid = (state_q == StResp) && (owner_q == OwnIf) && !kill_q;
    assign LsRvalid = (state_q == StResp) && (owner_q == OwnLs);
    assign IfRdata  = IfRvalid ? rdata_q : '0;
    assign LsRdata  = LsRvalid ? rdata_q : '0;
    assign HoldIf   = Rst && IfReq && !IfRvalid;
    assign HoldLs   = Rst && LsReq && !LsRvalid;

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign MemWmask = mem_wmask_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        rdata_d     = rdata_q;

        // A flush while a fetch is in flight drops its response but not the memory access.
        if (Flush && (owner_q == OwnIf) && ((state_q == StReq) || (state_q == StWait))) begin
            kill_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (IfGnt) begin
                    owner_d     = OwnIf;
                    kill_d      = Flush;
                    starve_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = IfAddr;
                    mem_wdata_d = '0;
                    mem_wmask_d = '0;
                    state_d     = StReq;
                end else if (LsGnt) begin
                    owner_d     = OwnLs;
                    kill_d      = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = LsWe;
                    mem_addr_d  = LsAddr;
                    mem_wdata_d = LsWdata;
                    mem_wmask_d = LsWmask;
                    state_d     = StReq;
                    if (IfReq && (starve_q != StarveLim)) begin
                        starve_d = starve_q + CntW'(1);
                    end
                end
            end
            StReq: begin
                if (MemGnt) begin
                    mem_req_d = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (MemRvalid) begin
                    rdata_d = mem_we_q ? '0 : MemRdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                kill_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            kill_q      <= 1'b0;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule
